// File: rtl/simple_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simple_datapath_pkg
// Description : Shared constants and the bus-source encoding for the
//               single-bus datapath slice.
// Revision    : 1.0 - initial release
// ============================================================================
package simple_datapath_pkg;

    localparam int WIDTH = 32;

    // Winning bus driver, as chosen by the priority encoder in the top.
    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_PC   = 3'd1,
        SRC_R3   = 3'd2,
        SRC_R2   = 3'd3,
        SRC_MDR  = 3'd4,
        SRC_ZLO  = 3'd5,
        SRC_ZHI  = 3'd6
    } bus_src_t;

endpackage : simple_datapath_pkg
`default_nettype wire

// File: rtl/simple_datapath_dp_reg.sv
`default_nettype none
// ============================================================================
// Module      : dp_reg
// Description : W-bit register with load enable and asynchronous active-low
//               clear. Holds its value when load is low.
// Ports       : clk   - rising-edge clock
//               rst_n - async active-low clear to RESET_VAL
//               load  - capture d on the next rising edge
//               d     - data in
//               q     - register contents
// Revision    : 1.0 - initial release
// ============================================================================
module dp_reg #(
    parameter int             W         = 32,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [W-1:0]  d,
    output logic [W-1:0]  q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule : dp_reg
`default_nettype wire

// File: rtl/simple_datapath.sv
`default_nettype none
// ============================================================================
// Module      : simple_datapath
// Description : Single-bus CPU datapath slice (R1-R3, PC, IR, MDR, Y, Z, HI)
//               supporting the AND instruction. Out strobes drive the shared
//               bus through a priority mux; in strobes capture it on the
//               rising clock edge.
// Ports       : clock/clear        - clock, async active-low reset
//               *out               - bus driver strobes
//               *in, Read, AND     - register load controls
//               Mdatain            - memory data into MDR
//               bus_mon, ir_mon,
//               r1_mon, hi_mon     - debug monitors
// Revision    : 1.0 - initial release
// ============================================================================
module simple_datapath
    import simple_datapath_pkg::*;
#(
    parameter int                 WIDTH     = simple_datapath_pkg::WIDTH,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              PCout,
    input  logic              Zlowout,
    input  logic              ZHighout,
    input  logic              MDRout,
    input  logic              R2out,
    input  logic              R3out,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Yin,
    input  logic              IRin,
    input  logic              R1in,
    input  logic              R2in,
    input  logic              R3in,
    input  logic              HIin,
    input  logic              AND,
    input  logic [WIDTH-1:0]  Mdatain,
    output logic [WIDTH-1:0]  bus_mon,
    output logic [WIDTH-1:0]  ir_mon,
    output logic [WIDTH-1:0]  r1_mon,
    output logic [WIDTH-1:0]  hi_mon
);

    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] pc_q, ir_q, mdr_q, y_q, zlo_q, zhi_q, hi_q;
    logic [WIDTH-1:0] r1_q, r2_q, r3_q;
    logic [WIDTH-1:0] mdr_d;
    logic [WIDTH-1:0] zlo_d;
    bus_src_t         src;

    // Priority encoder: several strobes may be high at once during bring-up.
    always_comb begin
        src = SRC_NONE;
        if      (ZHighout) src = SRC_ZHI;
        else if (Zlowout)  src = SRC_ZLO;
        else if (MDRout)   src = SRC_MDR;
        else if (R2out)    src = SRC_R2;
        else if (R3out)    src = SRC_R3;
        else if (PCout)    src = SRC_PC;
    end

    always_comb begin
        bus = '0;
        case (src)
            SRC_ZHI: bus = zhi_q;
            SRC_ZLO: bus = zlo_q;
            SRC_MDR: bus = mdr_q;
            SRC_R2:  bus = r2_q;
            SRC_R3:  bus = r3_q;
            SRC_PC:  bus = pc_q;
            default: bus = '0;
        endcase
    end

    assign mdr_d = Read ? Mdatain : bus;
    assign zlo_d = y_q & bus;

    // PC has no load path here; it only sources the bus at its reset value.
    dp_reg #(.W(WIDTH), .RESET_VAL(RESET_VAL)) u_pc
        (.clk(clock), .rst_n(clear), .load(1'b0), .d('0),    .q(pc_q));
    dp_reg #(.W(WIDTH), .RESET_VAL(RESET_VAL)) u_ir
        (.clk(clock), .rst_n(clear), .load(IRin), .d(bus),   .q(ir_q));
    dp_reg #(.W(WIDTH), .RESET_VAL(RESET_VAL)) u_mdr
        (.clk(clock), .rst_n(clear), .load(MDRin), .d(mdr_d), .q(mdr_q));
    dp_reg #(.W(WIDTH), .RESET_VAL(RESET_VAL)) u_y
        (.clk(clock), .rst_n(clear), .load(Yin),  .d(bus),   .q(y_q));
    dp_reg #(.W(WIDTH), .RESET_VAL(RESET_VAL)) u_r1
        (.clk(clock), .rst_n(clear), .load(R1in), .d(bus),   .q(r1_q));
    dp_reg #(.W(WIDTH), .RESET_VAL(RESET_VAL)) u_r2
        (.clk(clock), .rst_n(clear), .load(R2in), .d(bus),   .q(r2_q));
    dp_reg #(.W(WIDTH), .RESET_VAL(RESET_VAL)) u_r3
        (.clk(clock), .rst_n(clear), .load(R3in), .d(bus),   .q(r3_q));
    dp_reg #(.W(WIDTH), .RESET_VAL(RESET_VAL)) u_hi
        (.clk(clock), .rst_n(clear), .load(HIin), .d(bus),   .q(hi_q));

    // Z is split in two halves; the AND result always zero-fills the upper half.
    dp_reg #(.W(WIDTH), .RESET_VAL(RESET_VAL)) u_zlo
        (.clk(clock), .rst_n(clear), .load(AND),  .d(zlo_d), .q(zlo_q));
    dp_reg #(.W(WIDTH), .RESET_VAL(RESET_VAL)) u_zhi
        (.clk(clock), .rst_n(clear), .load(AND),  .d('0),    .q(zhi_q));

    assign bus_mon = bus;
    assign ir_mon  = ir_q;
    assign r1_mon  = r1_q;
    assign hi_mon  = hi_q;

endmodule : simple_datapath
`default_nettype wire

// File: tb/tb_simple_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_simple_datapath
// Description : Directed self-checking bench for simple_datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simple_datapath;

    logic        clock = 1'b0;
    logic        clear;
    logic        PCout, Zlowout, ZHighout, MDRout, R2out, R3out;
    logic        MDRin, Read, Yin, IRin, R1in, R2in, R3in, HIin, AND;
    logic [31:0] Mdatain;
    logic [31:0] bus_mon, ir_mon, r1_mon, hi_mon;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    simple_datapath dut (
        .clock(clock), .clear(clear),
        .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout),
        .MDRout(MDRout), .R2out(R2out), .R3out(R3out),
        .MDRin(MDRin), .Read(Read), .Yin(Yin), .IRin(IRin),
        .R1in(R1in), .R2in(R2in), .R3in(R3in), .HIin(HIin), .AND(AND),
        .Mdatain(Mdatain),
        .bus_mon(bus_mon), .ir_mon(ir_mon), .r1_mon(r1_mon), .hi_mon(hi_mon)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        {PCout, Zlowout, ZHighout, MDRout, R2out, R3out} = '0;
        {MDRin, Read, Yin, IRin, R1in, R2in, R3in, HIin, AND} = '0;
    endtask

    // Let one rising edge capture, then return to the falling edge.
    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Load MDR from memory, then move MDR to a destination chosen by the caller.
    task automatic mem_to_mdr(input logic [31:0] val);
        idle();
        Mdatain = val; Read = 1'b1; MDRin = 1'b1;
        cyc();
        idle();
    endtask

    initial begin
        logic [16:0] rnd;
        idle();
        Mdatain = '0;
        clear = 1'b0;

        // Reset with random strobes
        @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            rnd = 17'($urandom);
            {PCout, Zlowout, ZHighout, MDRout, R2out, R3out,
             MDRin, Read, Yin, IRin, R1in, R2in, R3in, HIin, AND} = rnd[14:0];
            Mdatain = $urandom;
            #1;
            check("rst_bus", bus_mon, 32'h0);
            cyc();
        end
        check("rst_ir", ir_mon, 32'h0);
        check("rst_r1", r1_mon, 32'h0);
        check("rst_hi", hi_mon, 32'h0);
        idle();
        clear = 1'b1;
        cyc();
        check("post_rst_r1", r1_mon, 32'h0);
        MDRout = 1'b1; #1;
        check("post_rst_mdr", bus_mon, 32'h0);

        // Register loads via MDR
        mem_to_mdr(32'h12);
        MDRout = 1'b1; R2in = 1'b1; cyc(); idle();
        mem_to_mdr(32'h14);
        MDRout = 1'b1; R3in = 1'b1; cyc(); idle();
        mem_to_mdr(32'h18);
        MDRout = 1'b1; R1in = 1'b1; cyc(); idle();
        check("r1_load", r1_mon, 32'h18);
        R2out = 1'b1; #1; check("r2_load", bus_mon, 32'h12); idle();
        R3out = 1'b1; #1; check("r3_load", bus_mon, 32'h14); idle();

        // IR fetch
        mem_to_mdr(32'h2);
        MDRout = 1'b1; IRin = 1'b1; cyc(); idle();
        check("ir_fetch", ir_mon, 32'h2);

        // Preload HI so the ZHigh transfer is observable
        MDRout = 1'b1; HIin = 1'b1; cyc(); idle();
        check("hi_pre", hi_mon, 32'h2);

        // AND flow
        R2out = 1'b1; Yin = 1'b1; cyc(); idle();
        R3out = 1'b1; AND = 1'b1; cyc(); idle();
        Zlowout = 1'b1; R1in = 1'b1; #1;
        check("zlo_bus", bus_mon, 32'h10);
        cyc(); idle();
        check("and_r1", r1_mon, 32'h10);
        ZHighout = 1'b1; HIin = 1'b1; #1;
        check("zhi_bus", bus_mon, 32'h0);
        cyc(); idle();
        check("and_hi", hi_mon, 32'h0);

        // AND reading old Z low in the same cycle: Y=0x06, Z=0x10 -> 0x00;
        // first make Z=0x14 with Y=0xFF, then Y=0x06 -> 0x04
        mem_to_mdr(32'hFF);
        MDRout = 1'b1; Yin = 1'b1; cyc(); idle();
        R3out = 1'b1; AND = 1'b1; cyc(); idle();
        Zlowout = 1'b1; #1; check("z_ff_and_r3", bus_mon, 32'h14); idle();
        mem_to_mdr(32'h06);
        MDRout = 1'b1; Yin = 1'b1; cyc(); idle();
        Zlowout = 1'b1; AND = 1'b1; cyc(); idle();
        Zlowout = 1'b1; #1; check("z_self_and", bus_mon, 32'h04); idle();

        // Same-cycle self rewrite of R2
        R2out = 1'b1; R2in = 1'b1; cyc(); idle();
        R2out = 1'b1; #1; check("r2_self", bus_mon, 32'h12); idle();

        // Bus priority
        mem_to_mdr(32'h5);
        MDRout = 1'b1; R2out = 1'b1; #1; check("pri_mdr_r2", bus_mon, 32'h5); idle();
        Zlowout = 1'b1; MDRout = 1'b1; #1; check("pri_zlo_mdr", bus_mon, 32'h04); idle();
        ZHighout = 1'b1; Zlowout = 1'b1; #1; check("pri_zhi_zlo", bus_mon, 32'h0); idle();
        R2out = 1'b1; R3out = 1'b1; #1; check("pri_r2_r3", bus_mon, 32'h12); idle();
        R3out = 1'b1; PCout = 1'b1; #1; check("pri_r3_pc", bus_mon, 32'h14); idle();
        PCout = 1'b1; #1; check("pc_bus", bus_mon, 32'h0); idle();
        #1; check("bus_none", bus_mon, 32'h0);

        // Level-sensitive load held several cycles; IR untouched
        MDRout = 1'b1; R1in = 1'b1; HIin = 1'b1;
        cyc(); cyc(); cyc(); idle();
        check("r1_hold3", r1_mon, 32'h5);
        check("hi_hold3", hi_mon, 32'h5);
        check("ir_hold", ir_mon, 32'h2);

        // Async clear mid-AND with Z nonzero (Y=0x06 & R3=0x14 -> 0x04)
        R3out = 1'b1; AND = 1'b1;
        cyc();
        #2 clear = 1'b0;
        #1;
        check("clr_r1", r1_mon, 32'h0);
        check("clr_hi", hi_mon, 32'h0);
        check("clr_ir", ir_mon, 32'h0);
        check("clr_r3", bus_mon, 32'h0);
        idle(); Zlowout = 1'b1; #0.5; check("clr_zlo", bus_mon, 32'h0);
        idle(); R2out = 1'b1; #0.5; check("clr_r2", bus_mon, 32'h0);
        idle();
        clear = 1'b1;
        @(negedge clock);

        // Loads resume after clear release
        mem_to_mdr(32'h77);
        MDRout = 1'b1; R1in = 1'b1; #1;
        check("resume_bus", bus_mon, 32'h77);
        cyc(); idle();
        check("resume_r1", r1_mon, 32'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_simple_datapath
`default_nettype wire

// File: doc/simple_datapath.md
Name: simple_datapath

Overview:
- 32-bit single-bus CPU datapath slice for Phase-1 bring-up of the AND instruction.
- Holds general registers R1–R3 plus PC, IR, MDR, Y, the 64-bit Z (ZHi:ZLo) and HI.
- All of these share one 32-bit internal bus.
- The bus is driven by one-hot "out" strobes; registers capture it on "in" strobes at the rising clock edge.
- A testbench or control unit sequences the strobes.

Parameters:
- WIDTH, 32, bus and register width. Z is 2*WIDTH.
- RESET_VAL, 0, value of every register after reset.

Ports:
- clock  in  1  system clock; all captures on rising edge.
- clear  in  1  asynchronous, active-low reset; while 0, all registers are held at RESET_VAL.
- PCout  in  1  drive PC onto bus.
- Zlowout  in  1  drive Z[31:0] onto bus.
- ZHighout  in  1  drive Z[63:32] onto bus.
- MDRout  in  1  drive MDR onto bus.
- R2out  in  1  drive R2 onto bus.
- R3out  in  1  drive R3 onto bus.
- MDRin  in  1  load MDR.
- Read  in  1  MDR source select: 1 = Mdatain, 0 = bus.
- Yin  in  1  load Y from bus.
- IRin  in  1  load IR from bus.
- R1in  in  1  load R1 from bus.
- R2in  in  1  load R2 from bus.
- R3in  in  1  load R3 from bus.
- HIin  in  1  load HI from bus.
- AND  in  1  ALU op: load Z with {32'h0, Y & bus}.
- Mdatain  in  32  memory data input.
- bus_mon  out  32  current bus value (combinational), for debug.
- ir_mon  out  32  IR contents.
- r1_mon  out  32  R1 contents.
- hi_mon  out  32  HI contents.

Behaviour:
- Reset: clear=0 asynchronously forces PC, IR, MDR, Y, Z, HI, R1, R2, R3 to 0. Monitors then read 0.
- Bus mux is combinational.
  - Priority when several out strobes are high: ZHighout > Zlowout > MDRout > R2out > R3out > PCout.
  - No out strobe high: bus = 32'h0.
- Register loads occur at posedge clock when the corresponding in strobe is 1; otherwise the register holds.
- MDR: if MDRin, MDR <= Read ? Mdatain : bus.
- Z: if AND, Z <= {32'h0, Y & bus}; otherwise Z holds. There is no separate Zin.
- PC has no load or increment path in this block; it holds its reset value.
- Same-cycle read and write is allowed; the capture uses the pre-edge bus value. Examples:
  - Zlowout with R1in copies Z low into R1.
  - R2out with R2in rewrites R2 with itself.
- AND with Zlowout in the same cycle: Z <= Y & old Z[31:0].
- Strobes are level-sensitive. A strobe held for N cycles loads N times; the final value is the same for a stable bus.
- clear asserted mid-sequence: immediate return to 0 regardless of strobes. Loads resume on the first rising edge after clear=1.
- Latency: one clock from an in strobe to the register output. The bus and monitors reflect out strobes combinationally.

Decomposition:
- Shared package:
  - WIDTH constant.
  - bus-source enumeration (SRC_NONE, SRC_PC, SRC_R3, SRC_R2, SRC_MDR, SRC_ZLO, SRC_ZHI) used by the priority encoder.
- One sub-module, dp_reg: WIDTH-bit register with load enable and async active-low clear.
  - Instantiated for each register.
  - Z is two instances, or one at 2*WIDTH.

Test Plan:
- Reset: clear=0 for 2 cycles with random strobes → all monitors 0 and bus 0; release clear → registers still 0.
- Register load via MDR:
  - Mdatain=0x12, Read=1, MDRin=1 one cycle, then MDRout=1, R2in=1 → R2=0x12.
  - Repeat with 0x14 into R3.
  - Repeat with 0x18 into R1 → r1_mon=0x18.
- IR fetch: Mdatain=0x2, Read=1, MDRin=1; then MDRout=1, IRin=1 → ir_mon=0x00000002.
- AND flow with R2=0x12, R3=0x14:
  - R2out, Yin → Y=0x12.
  - R3out, AND → Z=0x0000000000000010.
  - Zlowout, R1in → r1_mon=0x10.
  - ZHighout, HIin → hi_mon=0x0.
- Bus priority: MDR=0x5, R2=0x12, assert MDRout and R2out together → bus_mon=0x5. No out strobes → bus_mon=0.
- Async reset mid-op: during AND cycle with Z nonzero, pulse clear=0 between edges → Z, R1–R3 and HI drop to 0 immediately, without waiting for a clock edge.
